// File: rtl/msg_merger3.sv
// msg_merger3: 3-to-1 message merger for the split message fabric.
// Sources a, b and c present held messages (valid flag at bit VBIT) and are
// served round-robin; accepted messages go into a 2-entry FIFO whose head is
// driven on msgout, or default_option when the FIFO is empty.
//
// Optional build macro MSG_MERGER3_SRCTAG_EN: adds the srcid output, which
// carries the originating source of the FIFO head (1=a, 2=b, 3=c, 0=empty).
// Without the macro there is no srcid port and no tag storage.
module msg_merger3 #(
  parameter int WID  = 132,
  parameter int VBIT = WID - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [WID-1:0] msga,
  input  logic [WID-1:0] msgb,
  input  logic [WID-1:0] msgc,
  output logic           acka,
  output logic           ackb,
  output logic           ackc,
  output logic [WID-1:0] msgout,
  input  logic           msgoutack,
  input  logic [WID-1:0] default_option,
  output logic           busy
`ifdef MSG_MERGER3_SRCTAG_EN
  ,
  output logic [1:0]     srcid
`endif
);

  // Round-robin pick: search starts at the source after 'last' and wraps
  // 3->1. vld bit 0 is a, bit 1 is b, bit 2 is c. Returns 0 when none valid.
  function automatic logic [1:0] rr_pick(input logic [2:0] vld, input logic [1:0] last);
    logic [1:0] pick;
    pick = 2'd0;
    case (last)
      2'd1: begin
        if (vld[1])      pick = 2'd2;
        else if (vld[2]) pick = 2'd3;
        else if (vld[0]) pick = 2'd1;
        else             pick = 2'd0;
      end
      2'd2: begin
        if (vld[2])      pick = 2'd3;
        else if (vld[0]) pick = 2'd1;
        else if (vld[1]) pick = 2'd2;
        else             pick = 2'd0;
      end
      default: begin
        if (vld[0])      pick = 2'd1;
        else if (vld[1]) pick = 2'd2;
        else if (vld[2]) pick = 2'd3;
        else             pick = 2'd0;
      end
    endcase
    return pick;
  endfunction

  logic [2:0]     vld_s;
  logic [1:0]     grant_s;
  logic           room_s;
  logic           push_s;
  logic           pop_s;
  logic [WID-1:0] push_data_s;
  logic [WID-1:0] head_s;

  logic [1:0]     last_r;
  logic           run_r;
  logic [1:0]     count_r;
  logic           wr_ptr_r;
  logic           rd_ptr_r;
  logic [WID-1:0] mem_r [0:1];
`ifdef MSG_MERGER3_SRCTAG_EN
  logic [1:0]     tag_r [0:1];
`endif

  assign vld_s   = {msgc[VBIT], msgb[VBIT], msga[VBIT]};
  assign grant_s = rr_pick(vld_s, last_r);
  assign room_s  = (count_r < 2'd2);
  assign head_s  = mem_r[rd_ptr_r];

  // Acks come only from registered state and source valids (never msgoutack);
  // run_r keeps them low while in reset and during the release cycle.
  always_comb begin
    acka = 1'b0;
    ackb = 1'b0;
    ackc = 1'b0;
    if (run_r && room_s) begin
      acka = (grant_s == 2'd1);
      ackb = (grant_s == 2'd2);
      ackc = (grant_s == 2'd3);
    end else begin
      acka = 1'b0;
      ackb = 1'b0;
      ackc = 1'b0;
    end
  end

  assign push_s = acka | ackb | ackc;
  assign pop_s  = (count_r != 2'd0) && head_s[VBIT] && msgoutack;

  // Select the granted source's message as the FIFO write data.
  always_comb begin
    push_data_s = {WID{1'b0}};
    case (grant_s)
      2'd1:    push_data_s = msga;
      2'd2:    push_data_s = msgb;
      2'd3:    push_data_s = msgc;
      default: push_data_s = {WID{1'b0}};
    endcase
  end

  // Drive the FIFO head when non-empty, otherwise the external idle value.
  always_comb begin
    msgout = default_option;
    if (count_r != 2'd0) begin
      msgout = head_s;
    end else begin
      msgout = default_option;
    end
  end

  assign busy = (count_r != 2'd0);

`ifdef MSG_MERGER3_SRCTAG_EN
  // Source tag of the head; zero whenever the FIFO is empty.
  always_comb begin
    srcid = 2'd0;
    if (count_r != 2'd0) begin
      srcid = tag_r[rd_ptr_r];
    end else begin
      srcid = 2'd0;
    end
  end
`endif

  // Arbitration pointer advances only on a completed input transfer;
  // run_r enables acks from the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 2'd3;
      run_r  <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (push_s) begin
        last_r <= grant_s;
      end
    end
  end

  // FIFO occupancy and pointers; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // FIFO storage: message stored unmodified, including its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= {WID{1'b0}};
      mem_r[1] <= {WID{1'b0}};
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

`ifdef MSG_MERGER3_SRCTAG_EN
  // Per-entry source tag written alongside the message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r[0] <= 2'd0;
      tag_r[1] <= 2'd0;
    end else if (push_s) begin
      tag_r[wr_ptr_r] <= grant_s;
    end
  end
`endif

endmodule

// File: doc/msg_merger3.md
Name: msg_merger3

Overview:
- 3-to-1 message merger; the collecting end of the split message fabric.
- Takes up to three held message streams (a, b, c) and arbitrates among them round-robin.
- Buffers accepted messages in a 2-entry output FIFO and presents them one at a time on msgout, with ack-based flow control on both sides.
- Idle output value is supplied externally (default_option), the same idle convention the splitter uses.

Parameters:
- WID, 132, message width in bits.
- VBIT, WID-1, bit position of the message valid flag. Message present when msg[VBIT]==1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- msga  input  WID  source a message; held stable while msga[VBIT]=1 until acka.
- msgb  input  WID  source b message; same rule as msga.
- msgc  input  WID  source c message; same rule as msga.
- acka  output  1  source a message accepted this cycle.
- ackb  output  1  source b message accepted this cycle.
- ackc  output  1  source c message accepted this cycle.
- msgout  output  WID  merged message; equals default_option when FIFO empty.
- msgoutack  input  1  sink accepts msgout this cycle.
- default_option  input  WID  idle value driven on msgout when empty.
- busy  output  1  FIFO count != 0.

Behaviour:
- Transfer rule, both sides: a transfer occurs on a rising clk edge where the message valid bit is 1 and the matching ack is 1.
- Sources must hold the message until acked. Ack is a per-cycle accept, not a pulse train.
- Arbiter (combinational grant, registered pointer last[1:0] in {1,2,3}):
  - Candidates are the inputs with msgX[VBIT]=1.
  - Search order starts at the source after last, wrapping 3->1.
  - The first valid candidate is granted.
  - last updates to the granted source only on a completed input transfer.
- Ack generation: ackX = (grant==X) && (count<2). It depends only on registered state and input valids, never on msgoutack. At most one ack is high per cycle.
- FIFO: 2 entries, registered rd/wr pointers plus count[1:0] (0..2).
  - push = any ack. pop = msgout[VBIT] && msgoutack && count!=0.
  - push & pop with count 1: count stays 1, new entry written behind head.
  - push & pop with count 0: impossible, since pop requires count!=0. The entry written this cycle appears on msgout the next cycle (latency 1 clk from input transfer to msgout).
  - count 2: no ack even if pop occurs this cycle. The freed slot is usable next cycle.
  - msgoutack while empty: ignored, no state change.
- msgout = FIFO head when count!=0, else default_option. The head is stored unmodified, including the valid bit.
- Throughput: sustained 1 msg/clk when the sink acks every cycle.
- Reset (asynchronous, rst_n=0):
  - count=0, pointers=0, last=3, so a has first priority.
  - All acks=0 and busy=0 while in reset and at release.
  - msgout=default_option.
  - Reset mid-operation discards buffered messages. Sources still hold theirs and are re-arbitrated after release.
- Fairness: a source continuously valid waits at most 2 of its competitors' transfers.

Optional Feature:
- Macro MSG_MERGER3_SRCTAG_EN.
- Defined:
  - Adds output port srcid, 2 bits: the originating source of the FIFO head (1=a, 2=b, 3=c), matching the splitter's sel encoding.
  - srcid is stored per FIFO entry alongside the message.
  - srcid=0 when empty and in reset.
- Undefined: no srcid port, no tag storage. All other behaviour identical.

Test Plan:
- Single message: only msga valid (value 0x8..0001), sink acks → acka=1 for one cycle, msgout equals msga the next cycle, busy=1, then msgout=default_option after pop.
- Simultaneous sources: a, b, c all valid from reset, sink always acks → acks in order a,b,c, one per cycle; msgout sequence a,b,c; 3 messages in 3 consecutive cycles.
- Backpressure: msgoutack=0, a and b valid → two acks (a, then b), then no acks with count=2. Raise msgoutack → head a popped, next cycle ackc/next grant proceeds; no loss or duplication.
- Starvation: a valid continuously with new data, c valid once → c acked within 2 transfers of a.
- Reset mid-operation: assert rst_n=0 with count=2 → msgout=default_option and acks=0 immediately. After release, arbitration restarts with a first.
- SRCTAG (macro defined): order b then c → srcid 2 then 3 aligned with msgout; 0 when idle.
